// File: rtl/rv32i_exec_core.sv
// rv32i_exec_core: RV32I execute stage, covering decode/control, the branch comparator and the ALU.
// Every output is registered, so results appear one clock after their inputs.
module rv32i_exec_core #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_alu_data,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_pc_sel,
  output logic            o_br_equal,
  output logic            o_br_less,
  output logic            o_rd_wren,
  output logic            o_mem_wren,
  output logic [1:0]      o_wb_sel,
  output logic            o_insn_vld
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic alt, is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui, is_nop, legal;
  logic eq, lt, taken, sel, rd_wr, unused_ok;
  logic [XLEN-1:0] a, b, alu, res, pc4, npc;
  logic [1:0] wb;
  assign opc = i_inst[6:0];
  assign f3 = i_inst[14:12];
  assign alt = i_inst[30];
  assign unused_ok = ^{i_inst[31], i_inst[29:15]};
  assign is_r = opc == 7'b0110011;
  assign is_i = opc == 7'b0010011;
  assign is_ld = opc == 7'b0000011;
  assign is_st = opc == 7'b0100011;
  assign is_br = opc == 7'b1100011;
  assign is_jal = opc == 7'b1101111;
  assign is_jalr = opc == 7'b1100111;
  assign is_lui = opc == 7'b0110111;
  assign is_aui = opc == 7'b0010111;
  assign is_nop = opc == 7'b0001111 || opc == 7'b1110011;
  assign legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_aui | is_nop;
  assign a = (is_br | is_jal | is_aui) ? i_pc : is_lui ? '0 : i_rs1_data;
  assign b = is_r ? i_rs2_data : i_imm;
  always_comb begin
    alu = a + b;
    if (is_r || is_i)
      case (f3)
        3'b000: alu = (is_r && alt) ? a - b : a + b;
        3'b001: alu = a << b[4:0];
        3'b010: alu = {{XLEN-1{1'b0}}, $signed(a) < $signed(b)};
        3'b011: alu = {{XLEN-1{1'b0}}, a < b};
        3'b100: alu = a ^ b;
        3'b101: alu = alt ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'b110: alu = a | b;
        default: alu = a & b;
      endcase
  end
  // bltu/bgeu are the only unsigned comparisons; everything else compares signed
  assign eq = i_rs1_data == i_rs2_data;
  assign lt = (is_br && f3[2:1] == 2'b11) ? i_rs1_data < i_rs2_data
                                           : $signed(i_rs1_data) < $signed(i_rs2_data);
  assign taken = is_br & (f3[2] ? lt ^ f3[0] : ~f3[1] & (eq ^ f3[0]));
  assign sel = is_jal | is_jalr | taken;
  assign res = !legal ? '0 : is_jalr ? {alu[XLEN-1:1], 1'b0} : alu;
  assign pc4 = i_pc + XLEN'(4);
  assign npc = sel ? res : pc4;
  assign rd_wr = (i_inst[11:7] != 5'd0) & (is_r | is_i | is_lui | is_aui | is_ld | is_jal | is_jalr);
  assign wb = is_ld ? 2'b11 : (is_jal | is_jalr) ? 2'b10 : (is_r | is_i | is_lui | is_aui) ? 2'b00 : 2'b01;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_alu_data <= '0;
      o_next_pc  <= RESET_PC;
      o_pc_sel   <= 1'b0;
      o_br_equal <= 1'b0;
      o_br_less  <= 1'b0;
      o_rd_wren  <= 1'b0;
      o_mem_wren <= 1'b0;
      o_wb_sel   <= 2'b00;
      o_insn_vld <= 1'b0;
    end else begin
      o_alu_data <= res;
      o_next_pc  <= npc;
      o_pc_sel   <= sel;
      o_br_equal <= eq;
      o_br_less  <= lt;
      o_rd_wren  <= rd_wr;
      o_mem_wren <= is_st;
      o_wb_sel   <= wb;
      o_insn_vld <= legal;
    end
  end
endmodule

// File: tb/tb_rv32i_exec_core.sv
// tb_rv32i_exec_core: scoreboard bench for rv32i_exec_core; expected outputs come from an
// instruction-level reference model and are compared one cycle after each issue.
module tb_rv32i_exec_core;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUI = 7'b0010111, OP_FEN = 7'b0001111, OP_SYS = 7'b1110011;
  logic i_clk = 0, i_reset = 0;
  logic [31:0] i_inst = 0, i_pc = 0, i_rs1_data = 0, i_rs2_data = 0, i_imm = 0;
  logic [31:0] o_alu_data, o_next_pc;
  logic o_pc_sel, o_br_equal, o_br_less, o_rd_wren, o_mem_wren, o_insn_vld;
  logic [1:0] o_wb_sel;
  int n_chk = 0, n_fail = 0;
  logic [71:0] sb[$];
  logic [71:0] act;
  rv32i_exec_core dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_inst(i_inst), .i_pc(i_pc),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .o_alu_data(o_alu_data), .o_next_pc(o_next_pc), .o_pc_sel(o_pc_sel),
    .o_br_equal(o_br_equal), .o_br_less(o_br_less), .o_rd_wren(o_rd_wren),
    .o_mem_wren(o_mem_wren), .o_wb_sel(o_wb_sel), .o_insn_vld(o_insn_vld)
  );
  always #5 i_clk = ~i_clk;
  assign act = {o_alu_data, o_next_pc, o_pc_sel, o_br_equal, o_br_less, o_rd_wren, o_mem_wren, o_wb_sel, o_insn_vld};

  function automatic logic [31:0] ins(logic [6:0] op, logic [2:0] f3, logic alt, logic [4:0] rd);
    return {1'b0, alt, 5'd0, 5'd2, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] arith(logic [2:0] f3, logic alt, logic reg_op, logic [31:0] x, logic [31:0] y);
    case (f3)
      3'd0: return (reg_op && alt) ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [71:0] model(logic [31:0] inst, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
    logic [31:0] alu = 0;
    logic jump = 0, rdw = 0, memw = 0, vld = 1, eq, lt;
    logic [1:0] wb = 2'b01;
    logic [2:0] f3 = inst[14:12];
    eq = r1 == r2;
    lt = (inst[6:0] == OP_BR && (f3 == 3'd6 || f3 == 3'd7)) ? r1 < r2 : $signed(r1) < $signed(r2);
    case (inst[6:0])
      OP_R:    begin alu = arith(f3, inst[30], 1, r1, r2); rdw = 1; wb = 0; end
      OP_I:    begin alu = arith(f3, inst[30], 0, r1, imm); rdw = 1; wb = 0; end
      OP_LD:   begin alu = r1 + imm; rdw = 1; wb = 3; end
      OP_ST:   begin alu = r1 + imm; memw = 1; end
      OP_BR: begin
        alu = pc + imm;
        case (f3)
          3'd0: jump = eq;
          3'd1: jump = !eq;
          3'd4, 3'd6: jump = lt;
          3'd5, 3'd7: jump = !lt;
          default: jump = 0;
        endcase
      end
      OP_JAL:  begin alu = pc + imm; jump = 1; rdw = 1; wb = 2; end
      OP_JALR: begin alu = (r1 + imm) & ~32'd1; jump = 1; rdw = 1; wb = 2; end
      OP_LUI:  begin alu = imm; rdw = 1; wb = 0; end
      OP_AUI:  begin alu = pc + imm; rdw = 1; wb = 0; end
      OP_FEN, OP_SYS: alu = r1 + imm;
      default: vld = 0;
    endcase
    if (inst[11:7] == 0) rdw = 0;
    return {alu, jump ? alu : pc + 32'd4, jump, eq, lt, rdw, memw, wb, vld};
  endfunction

  task automatic issue(logic rst, logic [31:0] inst, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2, logic [31:0] imm);
    @(negedge i_clk);
    i_reset = rst; i_inst = inst; i_pc = pc; i_rs1_data = r1; i_rs2_data = r2; i_imm = imm;
    sb.push_back(rst ? {32'd0, 32'd0, 8'd0} : model(inst, pc, r1, r2, imm));
  endtask

  initial begin : monitor
    logic [71:0] e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_chk++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL outputs inst=%h: got alu=%h npc=%h flags=%b want alu=%h npc=%h flags=%b",
                   dut.i_inst, act[71:40], act[39:8], act[7:0], e[71:40], e[39:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    logic [6:0] ops[11] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI, OP_FEN, OP_SYS};
    issue(1, ins(OP_R, 0, 1, 5), 32'h100, 32'h5, 32'h7, 32'h20);
    issue(1, ins(OP_JAL, 0, 0, 1), 32'h200, 32'hFFFF_FFFF, 32'h1, 32'h44);
    issue(0, ins(OP_R, 0, 1, 5), 32'h0, 32'd5, 32'd7, 32'h0);
    issue(0, ins(OP_R, 5, 1, 5), 32'h4, 32'h8000_0000, 32'd4, 32'h0);
    issue(0, ins(OP_R, 3, 0, 5), 32'h8, 32'hFFFF_FFFF, 32'd1, 32'h0);
    issue(0, ins(OP_BR, 4, 0, 0), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    issue(0, ins(OP_BR, 6, 0, 0), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
    issue(0, ins(OP_BR, 0, 0, 0), 32'h100, 32'h1234, 32'h1234, 32'h20);
    issue(0, ins(OP_BR, 2, 0, 0), 32'h100, 32'h1, 32'h1, 32'h20);
    issue(0, ins(OP_JALR, 0, 0, 1), 32'h300, 32'h1003, 32'h0, 32'h0);
    issue(0, ins(OP_JAL, 0, 0, 0), 32'h300, 32'h0, 32'h0, 32'h40);
    issue(0, ins(OP_ST, 2, 0, 8), 32'h10, 32'h10, 32'h99, 32'h8);
    issue(0, ins(OP_LD, 2, 0, 3), 32'h14, 32'h10, 32'h0, 32'h4);
    issue(0, ins(OP_LUI, 0, 0, 4), 32'h18, 32'hDEAD, 32'h0, 32'h1234_5000);
    issue(0, ins(OP_AUI, 0, 0, 4), 32'h40, 32'hDEAD, 32'h0, 32'h1000);
    issue(0, ins(OP_I, 0, 1, 6), 32'h44, 32'h10, 32'h0, 32'h5);
    issue(0, ins(OP_I, 5, 1, 6), 32'h48, 32'h8000_0000, 32'h0, 32'h4);
    issue(0, ins(OP_FEN, 0, 0, 7), 32'h4C, 32'h1, 32'h2, 32'h3);
    issue(0, ins(OP_SYS, 0, 0, 7), 32'h50, 32'h1, 32'h2, 32'h3);
    issue(0, ins(7'h7F, 0, 0, 9), 32'h54, 32'h1, 32'h2, 32'h3);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst, r1, r2;
      inst = $urandom;
      if ($urandom_range(0, 7) != 0) inst[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 9) == 0) inst[11:7] = 0;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      issue(i % 97 == 50, inst, $urandom, r1, r2, $urandom);
    end
    @(negedge i_clk);
    i_reset = 0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge i_clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected results left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
